tessent_scanmux_nway_secure_ctrl: RTL

TESSENT_SCANMUX_NWAY_SECURE_CTRL -- requirements
Module: tessent_scanmux_nway_secure_ctrl

---
 rtl/tessent_scanmux_nway_secure_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/tessent_scanmux_nway_secure_ctrl.sv
// rtl/tessent_scanmux_nway_secure_ctrl.sv - key-protected N-way IJTAG scan mux control register
//
// Purpose:
//   IJTAG-style control register that selects one of NUM_IN scan paths.
//   A scan word carries an unlock key and a path select.
//   An update with the correct key moves the select into the update register.
//   An update with a wrong key forces the select back to RESET_SEL and sets a
//   sticky lock flag. Only reset clears the lock flag.
//
// Ports:
//   ijtag_tck    in  1       clock, rising edge
//   ijtag_reset  in  1       synchronous active-low reset
//   ijtag_sel    in  1       register selected; gates capture/shift/update
//   ijtag_ce     in  1       capture enable (highest priority)
//   ijtag_se     in  1       shift enable
//   ijtag_ue     in  1       update enable (lowest priority)
//   ijtag_si     in  1       scan-in
//   ijtag_so     out 1       scan-out (sr[0])
//   mux_in       in  NUM_IN  data inputs, bit i = path i
//   mux_out      out 1       selected data
//   enable_in    in  1       upstream path enable
//   enable_out   out NUM_IN  one-hot qualified enables
//   locked       out 1       sticky security-violation flag

module tessent_scanmux_nway_secure_ctrl #(
  parameter int               NUM_IN    = 4,
  parameter int               KEY_W     = 8,
  parameter logic [KEY_W-1:0] KEY_VALUE = KEY_W'(8'hA5),
  parameter int               RESET_SEL = 0
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [NUM_IN-1:0] mux_in,
  output logic              mux_out,
  input  logic              enable_in,
  output logic [NUM_IN-1:0] enable_out,
  output logic              locked
);

  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;
  localparam int SR_W  = KEY_W + SEL_W;

  localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL);
  // One extra bit so that NUM_IN itself is representable, e.g. NUM_IN=16.
  localparam logic [SEL_W:0]   NUM_IN_V    = (SEL_W + 1)'(NUM_IN);

  logic [SR_W-1:0]  r_sr;
  logic [SEL_W-1:0] r_sel_q;
  logic             r_lock_q;

  logic [KEY_W-1:0] w_key_field;
  logic [SEL_W-1:0] w_sel_field;
  logic             w_key_ok;
  logic             w_sel_ok;

  assign w_key_field = r_sr[SR_W-1:SEL_W];
  assign w_sel_field = r_sr[SEL_W-1:0];
  assign w_key_ok    = (w_key_field == KEY_VALUE);
  // Out-of-range selects are ignored so that sel_q always names a real path.
  assign w_sel_ok    = ({1'b0, w_sel_field} < NUM_IN_V);

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      r_sr     <= '0;
      r_sel_q  <= RESET_SEL_V;
      r_lock_q <= 1'b0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) begin
        // The key field is zeroed on capture so the key never leaks out.
        r_sr <= {{KEY_W{1'b0}}, r_sel_q};
      end else if (ijtag_se) begin
        r_sr <= {ijtag_si, r_sr[SR_W-1:1]};
      end else if (ijtag_ue && !r_lock_q) begin
        if (w_key_ok) begin
          if (w_sel_ok) begin
            r_sel_q <= w_sel_field;
          end
        end else begin
          r_sel_q  <= RESET_SEL_V;
          r_lock_q <= 1'b1;
        end
      end
    end
  end

  assign ijtag_so = r_sr[0];
  assign locked   = r_lock_q;

  always_comb begin
    mux_out    = 1'b0;
    enable_out = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_sel_q == SEL_W'(i)) begin
        mux_out       = mux_in[i];
        enable_out[i] = enable_in;
      end
    end
  end

endmodule
